// File: rtl/parity_tx_pkg.sv
// Shared definitions for the parity serial transmitter and its matching receiver:
// state encodings, the default bit period and the register bundle layout.
package parity_tx_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 16;
  localparam int unsigned BAUD_W          = 16;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned IDX_W           = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Everything the transmitter remembers between clock edges.
  typedef struct packed {
    state_e              state;
    logic [BAUD_W-1:0]   baud;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   data;
    logic                par;
    logic                txd;
  } tx_regs_t;

  // Idle line high, counters cleared, no byte held.
  localparam tx_regs_t TX_RESET = '{
    state: S_IDLE,
    baud:  '0,
    idx:   '0,
    data:  '0,
    par:   1'b0,
    txd:   1'b1
  };

endpackage

// File: rtl/parity_gen.sv
// Combinational XOR reduction of one byte; even/odd selection is left to the caller.
module parity_gen
  import parity_tx_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_tx.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Each bit lasts CLK_DIV clocks; txd comes straight from a flop.
module parity_tx
  import parity_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  output logic              ready,
  output logic              txd,
  output logic              done,
  output logic              par
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  tx_regs_t regs_q;
  tx_regs_t regs_d;
  logic     xor_in;
  logic     bit_end;

  // Parity is computed from the live input so it can be latched together with the byte.
  parity_gen u_parity_gen (
    .data_i   (data),
    .parity_o (xor_in)
  );

  assign bit_end = (regs_q.baud == BAUD_LAST);
  assign ready   = (regs_q.state == S_IDLE);
  assign txd     = regs_q.txd;
  assign par     = regs_q.par;

  // State register; reset also clears the held byte so par and txd start from a known value.
  // NOTE: the byte holder is an ordinary register here, so it takes the async reset like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= TX_RESET;
    end else begin
      // NOTE: non-blocking assignment so every flop samples the pre-edge value of regs_d.
      regs_q <= regs_d;
    end
  end

  // Next-state logic: baud timing, bit sequencing and the bit value to drive next.
  always_comb begin
    // NOTE: hold-by-default for every field keeps this block free of inferred latches.
    regs_d = regs_q;
    done   = 1'b0;

    if (regs_q.state != S_IDLE) begin
      regs_d.baud = bit_end ? '0 : regs_q.baud + 1'b1;
    end

    case (regs_q.state)
      S_IDLE: begin
        regs_d.txd = 1'b1;
        if (start) begin
          regs_d.state = S_START;
          regs_d.data  = data;
          regs_d.par   = xor_in ^ ODD_PARITY;
          regs_d.baud  = '0;
          regs_d.idx   = '0;
          regs_d.txd   = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          regs_d.state = S_DATA;
          regs_d.idx   = '0;
          regs_d.txd   = regs_q.data[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (regs_q.idx == IDX_LAST) begin
            // Last data bit finished: the index stops here instead of wrapping.
            regs_d.state = S_PARITY;
            regs_d.txd   = regs_q.par;
          end else begin
            regs_d.idx = regs_q.idx + 3'd1;
            regs_d.txd = regs_q.data[regs_d.idx];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          regs_d.state = S_STOP;
          regs_d.txd   = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          regs_d.state = S_IDLE;
          regs_d.txd   = 1'b1;
          done         = 1'b1;
        end
      end

      default: begin
        regs_d = TX_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: three instances (CLK_DIV=4 even, CLK_DIV=4 odd, CLK_DIV=2 even).
// Stimulus pushes the expected byte/parity into a per-instance queue; a receiver-style
// monitor per instance samples txd mid-cycle, decodes each frame and compares.
module tb_parity_tx;

  localparam int N_INST = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_r [N_INST];
  logic [7:0] data_r  [N_INST];
  logic       ready_w [N_INST];
  logic       txd_w   [N_INST];
  logic       done_w  [N_INST];
  logic       par_w   [N_INST];

  int checks   = 0;
  int failures = 0;
  int done_cnt [N_INST] = '{0, 0, 0};
  int pushed   [N_INST] = '{0, 0, 0};

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  always #5 clk = ~clk;

  parity_tx #(.CLK_DIV(4), .ODD_PARITY(1'b0)) u_even4 (
    .clk(clk), .rst(rst), .data(data_r[0]), .start(start_r[0]),
    .ready(ready_w[0]), .txd(txd_w[0]), .done(done_w[0]), .par(par_w[0])
  );

  parity_tx #(.CLK_DIV(4), .ODD_PARITY(1'b1)) u_odd4 (
    .clk(clk), .rst(rst), .data(data_r[1]), .start(start_r[1]),
    .ready(ready_w[1]), .txd(txd_w[1]), .done(done_w[1]), .par(par_w[1])
  );

  parity_tx #(.CLK_DIV(2), .ODD_PARITY(1'b0)) u_even2 (
    .clk(clk), .rst(rst), .data(data_r[2]), .start(start_r[2]),
    .ready(ready_w[2]), .txd(txd_w[2]), .done(done_w[2]), .par(par_w[2])
  );

  function automatic int div_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  // Reference parity: count the ones; even parity makes the total even, odd makes it odd.
  function automatic logic model_par(input int k, input logic [7:0] d);
    logic ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    return (k == 1) ? ~ones_odd : ones_odd;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.par  = model_par(k, d);
    pushed[k]++;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Count done pulses seen per instance.
  always @(negedge clk) begin
    for (int k = 0; k < N_INST; k++) begin
      if (done_w[k] === 1'b1) done_cnt[k]++;
    end
  end

  // Receiver model: on a low txd, capture 11 bit periods, decode and score.
  task automatic monitor(input int k);
    int         div;
    int         n;
    logic [10:0] bits;
    logic       par0, stable_ok, done_ok, ready_ok, par_ok, abort;
    exp_t       e;
    div = div_of(k);
    n   = 11 * div;
    forever begin
      @(negedge clk);
      if (!rst && txd_w[k] === 1'b0) begin
        bits      = '0;
        stable_ok = 1'b1;
        done_ok   = 1'b1;
        ready_ok  = 1'b1;
        par_ok    = 1'b1;
        abort     = 1'b0;
        par0      = par_w[k];
        for (int i = 0; i < n; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (i % div == 0) bits[i / div] = txd_w[k];
          else if (txd_w[k] !== bits[i / div]) stable_ok = 1'b0;
          if (done_w[k] !== ((i == n - 1) ? 1'b1 : 1'b0)) done_ok = 1'b0;
          if (ready_w[k] !== 1'b0) ready_ok = 1'b0;
          if (par_w[k] !== par0) par_ok = 1'b0;
        end
        if (!abort) begin
          check($sformatf("i%0d_frame_expected", k), q_size(k) != 0, 1);
          if (q_size(k) != 0) begin
            e = pop_exp(k);
            check($sformatf("i%0d_data", k), bits[8:1], e.data);
            check($sformatf("i%0d_parity_bit", k), bits[9], e.par);
            check($sformatf("i%0d_stop_bit", k), bits[10], 1);
            check($sformatf("i%0d_par_port", k), par0, e.par);
            check($sformatf("i%0d_bit_width", k), stable_ok, 1);
            check($sformatf("i%0d_done_position", k), done_ok, 1);
            check($sformatf("i%0d_ready_low", k), ready_ok, 1);
            check($sformatf("i%0d_par_stable", k), par_ok, 1);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Wait for ready, present one byte for one edge, then scramble data and optionally poke start.
  task automatic send(input int k, input logic [7:0] d, input bit noise, input bit record);
    int w;
    w = 0;
    @(negedge clk);
    while (ready_w[k] !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("i%0d_ready_wait", k), w < 500, 1);
    data_r[k]  = d;
    start_r[k] = 1'b1;
    if (record) push_exp(k, d);
    @(posedge clk);
    #1;
    start_r[k] = 1'b0;
    data_r[k]  = 8'($urandom);
    @(negedge clk);
    check($sformatf("i%0d_accept_latency", k), txd_w[k], 0);
    check($sformatf("i%0d_ready_after_accept", k), ready_w[k], 0);
    if (noise) begin
      repeat (2) @(negedge clk);
      start_r[k] = 1'b1;
      repeat (3) @(negedge clk);
      start_r[k] = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int k = 0; k < N_INST; k++) begin
      start_r[k] = 1'b0;
      data_r[k]  = 8'h00;
    end

    // Reset state, with a frame request already waiting on instance 0.
    start_r[0] = 1'b1;
    data_r[0]  = 8'hA5;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N_INST; k++) begin
      check($sformatf("i%0d_rst_txd", k), txd_w[k], 1);
      check($sformatf("i%0d_rst_ready", k), ready_w[k], 1);
      check($sformatf("i%0d_rst_done", k), done_w[k], 0);
      check($sformatf("i%0d_rst_par", k), par_w[k], 0);
    end
    push_exp(0, 8'hA5);
    #2 rst = 1'b0;
    #1 check("i0_no_accept_before_edge", txd_w[0], 1);
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    data_r[0]  = 8'h5A;
    @(negedge clk);
    check("i0_first_accept_latency", txd_w[0], 0);

    // Parity one for 0x07 under even parity.
    send(0, 8'h07, 1'b0, 1'b1);

    // Random bytes with random idle gaps and ignored start pokes mid-frame.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Start held high across three frames: exactly one idle-high cycle between them.
    start_r[0] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      w = 0;
      @(negedge clk);
      while (ready_w[0] !== 1'b1 && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (f > 0) begin
        check("i0_b2b_gap_cycles", w, 11 * 4);
        check("i0_b2b_idle_high", txd_w[0], 1);
      end
      data_r[0] = 8'($urandom);
      push_exp(0, data_r[0]);
      @(posedge clk);
      #1 check("i0_b2b_accepted", ready_w[0], 0);
    end
    start_r[0] = 1'b0;

    // Reset in the middle of data bit 3, then a clean frame.
    send(0, 8'h01, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    check("i0_mid_frame_bit3", txd_w[0], 0);
    #2 rst = 1'b1;
    #1;
    check("i0_async_rst_txd", txd_w[0], 1);
    check("i0_async_rst_ready", ready_w[0], 1);
    check("i0_async_rst_done", done_w[0], 0);
    check("i0_async_rst_par", par_w[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    send(0, 8'h3C, 1'b0, 1'b1);

    // Odd parity corner bytes and a few random ones.
    send(1, 8'h00, 1'b0, 1'b1);
    send(1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send(1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Every byte value through the CLK_DIV=2 instance.
    for (int i = 0; i < 256; i++) begin
      send(2, 8'(i), 1'b0, 1'b1);
    end

    // Let all frames drain, then every recorded frame must have produced exactly one done.
    w = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_queues_empty", q0.size() + q1.size() + q2.size(), 0);
    repeat (4) @(negedge clk);
    for (int k = 0; k < N_INST; k++) begin
      check($sformatf("i%0d_done_count", k), done_cnt[k], pushed[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_tx.md
PARITY_TX -- requirements
Module: parity_tx

Interface
REQ-001 Parameter CLK_DIV, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter ODD_PARITY, default 0, meaning 0 selects even parity and 1 selects odd parity.
REQ-003 Port clk  input  1  meaning the single system clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 Port data  input  8  meaning the byte to send; it is sampled only when a frame is accepted.
REQ-006 Port start  input  1  meaning the frame request, qualified by ready.
REQ-007 Port ready  output  1  meaning the transmitter is idle and will accept start.
REQ-008 Port txd  output  1  meaning the serial line, which idles high.
REQ-009 Port done  output  1  meaning a one-cycle pulse at the end of the stop bit.
REQ-010 Port par  output  1  meaning the parity bit of the latched byte, stable while the frame is in flight.

Function
REQ-011 The frame SHALL be: start bit 0, then data[0..7] LSB first, then the parity bit, then stop bit 1, for 11 bits totalling 11*CLK_DIV cycles.
REQ-012 With ODD_PARITY=0, par SHALL equal the XOR of the latched bits; with ODD_PARITY=1, par SHALL equal the inverse of that XOR.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with ready=1 only in IDLE.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch data, set par, and enter START; txd SHALL go to 0 in the following cycle, giving 1 cycle of acceptance latency.
REQ-015 Each state SHALL hold txd for exactly CLK_DIV cycles, timed by a baud counter that runs from 0 to CLK_DIV-1 and reloads to 0 on every bit boundary.
REQ-016 DATA SHALL use a 3-bit index from 0 to 7 and shift to PARITY after index 7 completes; the index SHALL not wrap into a ninth bit.
REQ-017 On the last cycle of STOP, done SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
REQ-018 Back-to-back frames: start held high SHALL be accepted in the first IDLE cycle after done, so the gap between stop and the next start bit is exactly 1 idle-high cycle.
REQ-019 start while ready=0 SHALL be ignored, and a change on data during a frame SHALL not affect txd or par.
REQ-020 txd SHALL be driven from a register and be glitch-free.

Reset
REQ-021 Asserting rst SHALL force, at any time including mid-frame: state=IDLE, txd=1, ready=1, done=0, par=0, baud counter=0, bit index=0, and data register=0.
REQ-022 The first frame after rst deasserts SHALL be accepted no earlier than the first rising edge with rst low.

Structure
REQ-023 The state encodings and the default CLK_DIV SHALL live in a shared include file (parity_tx_defs) so that the matching receiver reuses them.
REQ-024 The parity computation SHALL be the sub-module parity_gen: 8-bit in, 1-bit out, a combinational XOR reduction, with odd/even selection done in parity_tx.
REQ-025 The baud counter width SHALL be 16 bits.

Verification
REQ-026 CLK_DIV=4, even parity, data=8'hA5, start pulse → txd = 0,1,0,1,0,0,1,0,1,0,1 with each bit 4 cycles long, par=0, and done in cycle 44 after acceptance.
REQ-027 Even parity, data=8'h07 → par=1, and the parity bit on txd is 1.
REQ-028 ODD_PARITY=1, data=8'h00 → par=1; ODD_PARITY=1, data=8'hFF → par=1.
REQ-029 start held high for 3 frames → frames separated by exactly 1 high cycle, ready low throughout each frame, and 3 done pulses.
REQ-030 rst asserted during the DATA bit with index 3 → txd=1, ready=1 and done=0 immediately, without waiting for a clock; a new frame with data=8'h3C then completes correctly.
REQ-031 Exhaustive sweep of data 0..255 (CLK_DIV=2) → a receiver-side model decodes each frame and confirms the byte and the parity bit.
